ps2_kbd_rx: RTL and testbench

PS/2 keyboard receiver front end. It deserialises 11-bit PS/2 device-to-host frames and checks their framing and parity. Valid scan-code bytes are buffered in an 8-entry FIFO. The byte at the FIFO head is also shown as two hex digits on active-low 7-segment outputs. Upstream it connects to the raw PS/2 pins; downstream it feeds the keyboard-decode logic, which pops bytes using a ready/nextdata_n handshake.

---
 rtl/ps2_kbd_rx.sv | 114 +++++++++++
 tb/tb_ps2_kbd_rx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver with 8-entry scan-code FIFO and hex display
//
// Ports:
//   clk         system clock, all logic on its rising edge
//   clrn        asynchronous active-high clear
//   ps2_clk     raw PS/2 clock (asynchronous to clk)
//   ps2_data    raw PS/2 data
//   nextdata_n  active-low pop request
//   data        byte at the FIFO head, valid when ready=1
//   ready       FIFO non-empty
//   overflow    sticky: a valid frame was dropped because the FIFO was full
//   hex_h       active-low {g..a} pattern for data[7:4], blank when empty
//   hex_l       active-low {g..a} pattern for data[3:0], blank when empty
module ps2_kbd_rx #(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic [6:0] hex_h,
  output logic [6:0] hex_l
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  logic [2:0]    ps2_clk_sync;
  logic          sample;
  logic [9:0]    buffer;
  logic [3:0]    cnt;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    fifo [0:7];
  logic [2:0]    w_ptr;
  logic [2:0]    r_ptr;
  logic          full;
  logic          frame_ok;
  logic          push;
  logic          pop;

  // sync[2] is the older stage: 1 -> 0 across it marks a falling edge.
  assign sample   = ps2_clk_sync[2] & ~ps2_clk_sync[1];
  assign full     = (w_ptr + 3'd1) == r_ptr;
  assign ready    = w_ptr != r_ptr;
  assign frame_ok = ~buffer[0] & ps2_data & (^buffer[9:1]);
  assign push     = sample && (cnt == 4'd10) && frame_ok && !full;
  assign pop      = ready && !nextdata_n;

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      ps2_clk_sync <= 3'b111;
      cnt          <= 4'd0;
      idle_cnt     <= '0;
      buffer       <= 10'd0;
      w_ptr        <= 3'd0;
      r_ptr        <= 3'd0;
      overflow     <= 1'b0;
    end else begin
      ps2_clk_sync <= {ps2_clk_sync[1:0], ps2_clk};

      if (sample) begin
        idle_cnt <= '0;
        if (cnt == 4'd10) begin
          cnt <= 4'd0;
          if (frame_ok) begin
            if (full) overflow <= 1'b1;
            else      w_ptr    <= w_ptr + 3'd1;
          end
        end else begin
          buffer[cnt] <= ps2_data;
          cnt         <= cnt + 4'd1;
        end
      end else if (cnt != 4'd0) begin
        // A stalled partial frame is dropped so the next start bit realigns us.
        if (idle_cnt == IDLE_LAST) begin
          cnt      <= 4'd0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end

      if (pop) r_ptr <= r_ptr + 3'd1;
    end
  end

  // Storage needs no reset: ready gates every use of it.
  always_ff @(posedge clk) begin
    if (push) fifo[w_ptr] <= buffer[8:1];
  end

  assign data = fifo[r_ptr];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign hex_h = ready ? seg7(data[7:4]) : 7'h7F;
  assign hex_l = ready ? seg7(data[3:0]) : 7'h7F;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - directed self-checking bench for ps2_kbd_rx
module tb_ps2_kbd_rx;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic [6:0] hex_h;
  logic [6:0] hex_l;

  int vectors = 0;
  int miscompares = 0;

  ps2_kbd_rx #(.TIMEOUT(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready), .overflow(overflow),
    .hex_h(hex_h), .hex_l(hex_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends the first nbits of a frame; pop_stop pulls nextdata_n low on the stop-bit sample cycle.
  task automatic send_frame(input logic [7:0] b, input bit flip, input bit start,
                            input bit stop, input int nbits, input bit pop_stop);
    logic [10:0] f;
    f = {stop, (~^b) ^ flip, b, start};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (2) @(negedge clk);
      ps2_clk = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        nextdata_n = !(pop_stop && i == 10 && dut.sample && dut.cnt == 4'd10);
      end
      @(negedge clk);
      nextdata_n = 1'b1;
      ps2_clk = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b1, 11, 1'b0);
  endtask

  task automatic pop_one();
    @(negedge clk);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, {31'd0, ready}, 32'd1);
    check(tag, {24'd0, data}, {24'd0, exp});
    pop_one();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    clrn = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_hex_h", {25'd0, hex_h}, 32'h7F);
    check("rst_hex_l", {25'd0, hex_l}, 32'h7F);

    // single frame
    good(8'h1C);
    check("1c_ready", {31'd0, ready}, 32'd1);
    check("1c_data", {24'd0, data}, 32'h1C);
    check("1c_hex_h", {25'd0, hex_h}, 32'h79);
    check("1c_hex_l", {25'd0, hex_l}, 32'h46);
    check("1c_ovf", {31'd0, overflow}, 32'd0);
    pop_one();
    check("1c_popped", {31'd0, ready}, 32'd0);

    // bad frames: parity, start, stop
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 11, 1'b0);
    check("bad_par_ready", {31'd0, ready}, 32'd0);
    check("bad_par_cnt", {28'd0, dut.cnt}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 11, 1'b0);
    check("bad_start_ready", {31'd0, ready}, 32'd0);
    check("bad_start_cnt", {28'd0, dut.cnt}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 11, 1'b0);
    check("bad_stop_ready", {31'd0, ready}, 32'd0);
    check("bad_stop_cnt", {28'd0, dut.cnt}, 32'd0);
    good(8'h5A);
    check("5a_hex_h", {25'd0, hex_h}, 32'h12);
    check("5a_hex_l", {25'd0, hex_l}, 32'h08);
    pop_check("5a", 8'h5A);

    // break sequence
    good(8'hF0);
    good(8'h1C);
    pop_check("brk_f0", 8'hF0);
    pop_check("brk_1c", 8'h1C);
    check("brk_empty", {31'd0, ready}, 32'd0);
    check("brk_hex_h", {25'd0, hex_h}, 32'h7F);
    check("brk_hex_l", {25'd0, hex_l}, 32'h7F);

    // FIFO full
    for (int i = 1; i <= 8; i++) good(8'(i));
    check("full_ovf", {31'd0, overflow}, 32'd1);
    check("full_count", {29'd0, 3'(dut.w_ptr - dut.r_ptr)}, 32'd7);
    for (int i = 1; i <= 7; i++) pop_check($sformatf("full_pop%0d", i), 8'(i));
    check("full_empty", {31'd0, ready}, 32'd0);

    // simultaneous push and pop
    good(8'h11);
    good(8'h22);
    good(8'h33);
    check("sim_head", {24'd0, data}, 32'h11);
    send_frame(8'h44, 1'b0, 1'b0, 1'b1, 11, 1'b1);
    check("sim_count", {29'd0, 3'(dut.w_ptr - dut.r_ptr)}, 32'd3);
    pop_check("sim_22", 8'h22);
    pop_check("sim_33", 8'h33);
    pop_check("sim_44", 8'h44);
    check("sim_empty", {31'd0, ready}, 32'd0);

    // timeout recovery
    send_frame(8'h29, 1'b0, 1'b0, 1'b1, 5, 1'b0);
    check("to_partial_cnt", {28'd0, dut.cnt}, 32'd5);
    repeat (TO + 1) @(negedge clk);
    check("to_cnt", {28'd0, dut.cnt}, 32'd0);
    good(8'h29);
    check("to_data", {24'd0, data}, 32'h29);
    check("to_ready", {31'd0, ready}, 32'd1);

    // asynchronous reset mid-frame (overflow still set from the full test)
    send_frame(8'h29, 1'b0, 1'b0, 1'b1, 4, 1'b0);
    @(negedge clk);
    clrn = 1'b1;
    #1;
    check("arst_ready", {31'd0, ready}, 32'd0);
    check("arst_ovf", {31'd0, overflow}, 32'd0);
    check("arst_cnt", {28'd0, dut.cnt}, 32'd0);
    @(negedge clk);
    clrn = 1'b0;
    good(8'h3E);
    check("post_rst_data", {24'd0, data}, 32'h3E);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
